// File: rtl/ps2_scan_code_decoder.sv
// PS/2 Set-2 scan code decoder: folds E0/F0/E1 prefix sequences into make/break
// events and queues them in a first-word fall-through FIFO with valid/ready output.
module ps2_scan_code_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic       event_ready,
  input  logic       clear_overflow,
  output logic       event_valid,
  output logic [7:0] event_code,
  output logic       event_extended,
  output logic       event_break,
  output logic       overflow,
  output logic       decoder_busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_skip, w_skip_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic          w_push;
  logic [9:0]    w_push_data;

  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_pop, w_full, w_push_ok, w_drop;
  logic [9:0]    w_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_skip  <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_skip  <= w_skip_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  // Entry layout: {break, extended, code}
  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip;
    w_tmo_nxt   = r_tmo;
    w_push      = 1'b0;
    w_push_data = '0;
    if (r_state != S_IDLE) begin
      if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) w_state_nxt = S_IDLE;
      else                                  w_tmo_nxt   = r_tmo + TW'(1);
    end
    // A strobe overrides any timeout in the same cycle.
    if (received_data_en) begin
      w_tmo_nxt = '0;
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
          case (received_data)
            8'hE0: w_state_nxt = S_EXT;
            8'hF0: w_state_nxt = S_BRK;
            8'hE1: begin
              w_state_nxt = S_PAUSE;
              w_skip_nxt  = 3'd7;
            end
            8'hFA, 8'hAA, 8'hEE, 8'hFC, 8'hFD, 8'hFE, 8'h00, 8'hFF: ;
            default: begin
              w_push      = 1'b1;
              w_push_data = {2'b00, received_data};
            end
          endcase
        end
        S_EXT: begin
          if (received_data == 8'hF0) begin
            w_state_nxt = S_EXT_BRK;
          end else begin
            w_state_nxt = S_IDLE;
            if (received_data != 8'h12 && received_data != 8'h59) begin
              w_push      = 1'b1;
              w_push_data = {2'b01, received_data};
            end
          end
        end
        S_BRK: begin
          w_state_nxt = S_IDLE;
          w_push      = 1'b1;
          w_push_data = {2'b10, received_data};
        end
        S_EXT_BRK: begin
          w_state_nxt = S_IDLE;
          if (received_data != 8'h12 && received_data != 8'h59) begin
            w_push      = 1'b1;
            w_push_data = {2'b11, received_data};
          end
        end
        S_PAUSE: begin
          if (r_skip == 3'd1) begin
            w_state_nxt = S_IDLE;
            w_push      = 1'b1;
            w_push_data = {2'b01, 8'h77};
          end else begin
            w_state_nxt = S_PAUSE;
            w_skip_nxt  = r_skip - 3'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    if (w_state_nxt == S_IDLE) w_tmo_nxt = '0;
  end

  assign event_valid = (r_count != '0);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_pop       = event_valid & event_ready;
  assign w_push_ok   = w_push & (~w_full | w_pop);
  assign w_drop      = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  assign w_head         = r_mem[r_rd_ptr];
  assign event_code     = event_valid ? w_head[7:0] : 8'h00;
  assign event_extended = event_valid & w_head[8];
  assign event_break    = event_valid & w_head[9];
  assign overflow       = r_overflow;
  assign decoder_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_ps2_scan_code_decoder.sv
// Directed bench for ps2_scan_code_decoder: prefix decoding, drops, timeout,
// FIFO overflow/backpressure and mid-sequence reset.
module tb_ps2_scan_code_decoder;
  localparam int DEPTH = 4;
  localparam int TMO   = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       event_ready = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       event_valid;
  logic [7:0] event_code;
  logic       event_extended;
  logic       event_break;
  logic       overflow;
  logic       decoder_busy;

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] evq[$];

  ps2_scan_code_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .received_data(received_data),
    .received_data_en(received_data_en), .event_ready(event_ready),
    .clear_overflow(clear_overflow), .event_valid(event_valid),
    .event_code(event_code), .event_extended(event_extended),
    .event_break(event_break), .overflow(overflow), .decoder_busy(decoder_busy)
  );

  always #5 clk = ~clk;

  // Records each event that will be popped at the next rising edge.
  always begin
    @(negedge clk);
    #1;
    if (event_valid && event_ready) evq.push_back({event_break, event_extended, event_code});
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    if (event_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", event_valid); n_err++; end
    n_vec++;
    if (event_code !== 8'h00) begin $display("FAIL reset_code got %h want 00", event_code); n_err++; end
    n_vec++;
    if ({event_extended, event_break} !== 2'b00) begin $display("FAIL reset_flags got %b want 00", {event_extended, event_break}); n_err++; end
    n_vec++;
    if (overflow !== 1'b0) begin $display("FAIL reset_overflow got %b want 0", overflow); n_err++; end
    n_vec++;
    if (decoder_busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", decoder_busy); n_err++; end
    n_vec++;
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(2);
    if ({event_valid, decoder_busy} !== 2'b00) begin $display("FAIL post_reset got %b want 00", {event_valid, decoder_busy}); n_err++; end
    n_vec++;
  endtask

  task automatic test_make_break;
    logic [9:0] exp [2];
    exp[0] = 10'h01C;
    exp[1] = 10'h21C;
    event_ready = 1'b1;
    evq.delete();
    @(negedge clk);
    received_data = 8'h1C;
    received_data_en = 1'b1;
    #1;
    if (event_valid !== 1'b0) begin $display("FAIL mb_valid_before got %b want 0", event_valid); n_err++; end
    n_vec++;
    @(negedge clk);
    received_data_en = 1'b0;
    if (event_valid !== 1'b1) begin $display("FAIL mb_latency got %b want 1", event_valid); n_err++; end
    n_vec++;
    send_byte(8'hF0);
    send_byte(8'h1C);
    idle_cycles(4);
    if (evq.size() != 2) begin $display("FAIL mb_count got %0d want 2", evq.size()); n_err++; end
    n_vec++;
    for (int i = 0; i < 2 && i < evq.size(); i++) begin
      if (evq[i] !== exp[i]) begin $display("FAIL mb_event%0d got %h want %h", i, evq[i], exp[i]); n_err++; end
      n_vec++;
    end
  endtask

  task automatic test_extended;
    logic [7:0] bytes [16];
    logic [9:0] exp [4];
    bytes = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12, 8'hE0,
              8'h7C, 8'hE0, 8'hF0, 8'h12, 8'hE0, 8'hF0, 8'h7C, 8'hE0};
    exp = '{10'h175, 10'h375, 10'h17C, 10'h37C};
    event_ready = 1'b1;
    evq.delete();
    for (int i = 0; i < 15; i++) send_byte(bytes[i]);
    idle_cycles(4);
    if (evq.size() != 4) begin $display("FAIL ext_count got %0d want 4", evq.size()); n_err++; end
    n_vec++;
    for (int i = 0; i < 4 && i < evq.size(); i++) begin
      if (evq[i] !== exp[i]) begin $display("FAIL ext_event%0d got %h want %h", i, evq[i], exp[i]); n_err++; end
      n_vec++;
    end
  endtask

  task automatic test_pause;
    logic [7:0] bytes [8];
    bytes = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    event_ready = 1'b1;
    evq.delete();
    for (int i = 0; i < 7; i++) begin
      send_byte(bytes[i]);
      if (decoder_busy !== 1'b1) begin $display("FAIL pause_busy%0d got %b want 1", i, decoder_busy); n_err++; end
      n_vec++;
    end
    if (evq.size() != 0) begin $display("FAIL pause_early got %0d events want 0", evq.size()); n_err++; end
    n_vec++;
    send_byte(bytes[7]);
    if (decoder_busy !== 1'b0) begin $display("FAIL pause_busy_end got %b want 0", decoder_busy); n_err++; end
    n_vec++;
    idle_cycles(3);
    if (evq.size() != 1) begin $display("FAIL pause_count got %0d want 1", evq.size()); n_err++; end
    else if (evq[0] !== 10'h177) begin $display("FAIL pause_event got %h want 177", evq[0]); n_err++; end
    n_vec++;
  endtask

  task automatic test_drop_timeout;
    logic [7:0] drops [8];
    drops = '{8'hFA, 8'hAA, 8'hEE, 8'hFC, 8'hFD, 8'hFE, 8'h00, 8'hFF};
    event_ready = 1'b1;
    evq.delete();
    for (int i = 0; i < 8; i++) send_byte(drops[i]);
    if (decoder_busy !== 1'b0) begin $display("FAIL drop_busy got %b want 0", decoder_busy); n_err++; end
    n_vec++;
    send_byte(8'hF0);
    idle_cycles(TMO - 1);
    if (decoder_busy !== 1'b1) begin $display("FAIL tmo_early got %b want 1", decoder_busy); n_err++; end
    n_vec++;
    idle_cycles(1);
    if (decoder_busy !== 1'b0) begin $display("FAIL tmo_expire got %b want 0", decoder_busy); n_err++; end
    n_vec++;
    send_byte(8'h1C);
    idle_cycles(3);
    if (evq.size() != 1) begin $display("FAIL tmo_count got %0d want 1", evq.size()); n_err++; end
    else if (evq[0] !== 10'h01C) begin $display("FAIL tmo_event got %h want 01C", evq[0]); n_err++; end
    n_vec++;
  endtask

  task automatic test_overflow;
    logic [7:0] codes [5];
    logic [9:0] exp [4];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    exp = '{10'h01D, 10'h024, 10'h02D, 10'h035};
    event_ready = 1'b0;
    evq.delete();
    for (int i = 0; i < 4; i++) send_byte(codes[i]);
    if (overflow !== 1'b0) begin $display("FAIL ovf_at_full got %b want 0", overflow); n_err++; end
    n_vec++;
    send_byte(codes[4]);
    if (overflow !== 1'b1) begin $display("FAIL ovf_set got %b want 1", overflow); n_err++; end
    n_vec++;
    if ({event_valid, event_extended, event_break, event_code} !== 11'h415) begin
      $display("FAIL ovf_head got %h want 415", {event_valid, event_extended, event_break, event_code}); n_err++;
    end
    n_vec++;
    @(negedge clk);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    if (overflow !== 1'b0) begin $display("FAIL ovf_clear got %b want 0", overflow); n_err++; end
    n_vec++;
    @(negedge clk);
    received_data = 8'h35;
    received_data_en = 1'b1;
    event_ready = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
    event_ready = 1'b0;
    if (overflow !== 1'b0) begin $display("FAIL ovf_pushpop got %b want 0", overflow); n_err++; end
    n_vec++;
    if (evq.size() != 1 || evq[0] !== 10'h015) begin $display("FAIL ovf_popped got %0d entries want one 015", evq.size()); n_err++; end
    n_vec++;
    if (event_code !== 8'h1D) begin $display("FAIL ovf_newhead got %h want 1D", event_code); n_err++; end
    n_vec++;
    evq.delete();
    event_ready = 1'b1;
    idle_cycles(7);
    if (evq.size() != 4) begin $display("FAIL ovf_drain got %0d want 4", evq.size()); n_err++; end
    n_vec++;
    for (int i = 0; i < 4 && i < evq.size(); i++) begin
      if (evq[i] !== exp[i]) begin $display("FAIL ovf_event%0d got %h want %h", i, evq[i], exp[i]); n_err++; end
      n_vec++;
    end
  endtask

  task automatic test_reset_mid;
    event_ready = 1'b0;
    evq.delete();
    send_byte(8'h16);
    send_byte(8'h1E);
    send_byte(8'h26);
    send_byte(8'hE0);
    if ({event_valid, decoder_busy} !== 2'b11) begin $display("FAIL rst_mid_pre got %b want 11", {event_valid, decoder_busy}); n_err++; end
    n_vec++;
    reset = 1'b1;
    #1;
    if ({event_valid, decoder_busy} !== 2'b00) begin $display("FAIL rst_mid_now got %b want 00", {event_valid, decoder_busy}); n_err++; end
    n_vec++;
    idle_cycles(2);
    reset = 1'b0;
    send_byte(8'h1C);
    if ({event_valid, event_extended, event_break, event_code} !== 11'h41C) begin
      $display("FAIL rst_mid_head got %h want 41C", {event_valid, event_extended, event_break, event_code}); n_err++;
    end
    n_vec++;
    event_ready = 1'b1;
    idle_cycles(4);
    if (evq.size() != 1) begin $display("FAIL rst_mid_count got %0d want 1", evq.size()); n_err++; end
    n_vec++;
  endtask

  initial begin
    test_reset;
    test_make_break;
    test_extended;
    test_pause;
    test_drop_timeout;
    test_overflow;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_scan_code_decoder.md
Name: ps2_scan_code_decoder

Overview:
- Downstream stage of the PS2 byte receiver. Consumes each received byte (8-bit data plus a one-cycle enable) and assembles Set-2 prefix sequences (E0, F0, E1) into key make/break events.
- Buffers events in a small FWFT FIFO with valid/ready output for the keyboard application logic.
- Discards controller response bytes and the print-screen fake-shift bytes.

Parameters:
- FIFO_DEPTH, 4: event FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 200000: clk cycles a partial prefix sequence may wait for its next byte (2 ms at 100 MHz) before being abandoned.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- received_data  input  8  byte from PS2 receiver; valid only when received_data_en=1.
- received_data_en  input  1  one-cycle strobe, new byte present.
- event_ready  input  1  consumer accepts the head event this cycle.
- clear_overflow  input  1  clears the overflow flag.
- event_valid  output  1  FIFO non-empty; head event presented.
- event_code  output  8  Set-2 key code of head event.
- event_extended  output  1  head event was E0-prefixed, or is the pause key.
- event_break  output  1  1 = key release, 0 = key press.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- decoder_busy  output  1  FSM not in IDLE (partial sequence held).

Behaviour:
- Reset (async, while reset=1): FSM to IDLE; FIFO read/write pointers and count to 0; timeout counter 0; event_valid=0, event_code=0, event_extended=0, event_break=0, overflow=0, decoder_busy=0.
- Reset mid-sequence or mid-FIFO drops all partial state and stored events.
- FSM states and transitions (act only on cycles where received_data_en=1):
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> PAUSE with skip count 7.
    - FA, AA, EE, FC, FD, FE, 00, FF -> dropped; stay IDLE.
    - Any other byte -> push {code, ext=0, brk=0}.
  - EXT:
    - F0 -> EXT_BRK.
    - 12 or 59 (fake shift) -> dropped, IDLE.
    - Else -> push {code, 1, 0}, IDLE.
  - BRK: any byte -> push {code, 0, 1}, IDLE.
  - EXT_BRK:
    - 12 or 59 -> dropped, IDLE.
    - Else -> push {code, 1, 1}, IDLE.
  - PAUSE: each byte decrements the skip count. When the 7th byte arrives, push {77, 1, 0} and go to IDLE. No break event exists for pause.
- Timeout: the counter clears on every strobe and on entering IDLE, and increments in non-IDLE states. When it reaches TIMEOUT_CYCLES-1 without a strobe, the FSM returns to IDLE and nothing is pushed.
- If a strobe and the timeout coincide, the strobe wins.
- Latency: a push from the strobe in cycle N makes event_valid=1 in cycle N+1 when the FIFO was empty.
- FIFO:
  - First-word fall-through. Outputs are driven from the head entry and are held stable while event_valid=1 and event_ready=0.
  - Pop occurs when event_valid & event_ready.
  - Push is accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop happens the same cycle; count is then unchanged.
  - A push while full without a pop: the event is dropped and overflow is set to 1.
  - Pointers wrap modulo FIFO_DEPTH.
  - event_ready while empty has no effect.
- overflow stays set until clear_overflow=1. If a clear and a new drop happen in the same cycle, the set wins.
- decoder_busy = (state != IDLE), registered with the state.

Test Plan:
- Bytes 1C, then F0 1C; event_ready=1 -> two events {1C,0,0} and {1C,0,1}; first event_valid one cycle after the 1C strobe.
- Bytes E0 75, then E0 F0 75 -> events {75,1,0} and {75,1,1}. Bytes E0 12 E0 7C -> single event {7C,1,0}; the fake shift is suppressed.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {77,1,0}; decoder_busy high from after the first E1 until the last byte.
- Bytes FA, AA, then F0 followed by a silence of TIMEOUT_CYCLES, then 1C -> no events for FA/AA/F0; the FSM returns to IDLE; 1C yields {1C,0,0}, not a break.
- event_ready=0; push 5 events with FIFO_DEPTH=4 -> first four retained in order, fifth dropped, overflow=1. Then clear_overflow -> overflow=0. Then push while full with event_ready=1 in the same cycle -> push accepted, count stays 4, overflow stays 0.
- Assert reset while in EXT with 3 events queued -> event_valid=0 and decoder_busy=0 immediately. Then 1C -> {1C,0,0}, with no extended flag.
